vend_controller: RTL

Central vending-machine sequencer. Consumes single-cycle, edge-synchronised button/coin pulses from the upstream button synchronizers. Tracks inserted credit, authorises a vend when credit covers PRICE, and pays change or refunds greedily, one coin at a time. Drives the dispense actuator, the coin-return actuators and the credit display.

---
 rtl/vend_pkg.sv | 18 +
 rtl/change_dispenser.sv | 66 ++++++
 rtl/vend_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: sequencer state encoding,
// coin values in cents and the credit register width.
package vend_pkg;

  localparam int unsigned CREDIT_W = 8;

  localparam logic [CREDIT_W-1:0] NICKEL_VAL  = 8'd5;
  localparam logic [CREDIT_W-1:0] DIME_VAL    = 8'd10;
  localparam logic [CREDIT_W-1:0] QUARTER_VAL = 8'd25;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } vend_state_t;

endpackage

// File: rtl/change_dispenser.sv
// Greedy coin-return sequencer. Each returned coin takes a pulse cycle
// followed by a gap cycle.
//   Clk, Rst    : clock, synchronous active-high reset
//   start       : high in the cycle before CHANGE is entered (first pulse next)
//   active      : controller is currently in CHANGE
//   credit      : current credit in cents
//   ret_*       : registered 1-cycle coin-return pulses
//   dec         : amount the controller subtracts from credit at this edge
//   done        : credit exhausted and gap cycle reached; leave CHANGE
module change_dispenser
  import vend_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                start,
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  output logic                ret_nickel,
  output logic                ret_dime,
  output logic                ret_quarter,
  output logic [CREDIT_W-1:0] dec,
  output logic                done
);

  logic in_pulse;
  logic fire;
  logic pick_n, pick_d, pick_q;

  // A visible ret_* pulse means the current cycle is a pulse cycle, so the
  // pulse/gap toggle is simply the OR of the registered outputs.
  assign in_pulse = ret_nickel | ret_dime | ret_quarter;

  always_comb begin
    fire   = start | (active & ~in_pulse & (credit != '0));
    done   = active & ~in_pulse & (credit == '0);
    dec    = '0;
    pick_n = 1'b0;
    pick_d = 1'b0;
    pick_q = 1'b0;
    if (fire) begin
      if (credit >= QUARTER_VAL) begin
        pick_q = 1'b1;
        dec    = QUARTER_VAL;
      end else if (credit >= DIME_VAL) begin
        pick_d = 1'b1;
        dec    = DIME_VAL;
      end else begin
        pick_n = 1'b1;
        dec    = NICKEL_VAL;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ret_nickel  <= 1'b0;
      ret_dime    <= 1'b0;
      ret_quarter <= 1'b0;
    end else begin
      ret_nickel  <= pick_n;
      ret_dime    <= pick_d;
      ret_quarter <= pick_q;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending-machine sequencer: accumulates coin credit, vends when credit
// covers PRICE, then pays out remaining credit greedily.
//   Clk, Rst                     : clock, synchronous active-high reset
//   nickel_in/dime_in/quarter_in : 1-cycle coin-inserted pulses
//   select_in, cancel_in         : 1-cycle buy / refund requests
//   credit                       : current credit in cents
//   dispense                     : high DISP_CYCLES cycles per vend
//   ret_nickel/dime/quarter      : 1-cycle coin-return pulses
//   coin_reject                  : 1-cycle pulse, inserted coin not accepted
//   busy                         : high while in VEND or CHANGE
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 65,
  parameter int unsigned MAX_CREDIT  = 195,
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       quarter_in,
  input  logic       select_in,
  input  logic       cancel_in,
  output logic [7:0] credit,
  output logic       dispense,
  output logic       ret_nickel,
  output logic       ret_dime,
  output logic       ret_quarter,
  output logic       coin_reject,
  output logic       busy
);

  localparam int unsigned CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DISP_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PRICE_V  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_V    = (CREDIT_W + 1)'(MAX_CREDIT);

  vend_state_t state, state_next;
  logic [CREDIT_W-1:0] credit_next, coin_val, dec;
  logic [CREDIT_W:0]   sum;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic any_coin, multi_coin, accepting, do_select, do_cancel, coin_add;
  logic start, active, done, dispense_next, reject_next;

  // Event decode kept separate from next-state logic so the dispenser's
  // combinational dec path (start -> dec -> credit_next) stays acyclic.
  always_comb begin
    any_coin    = nickel_in | dime_in | quarter_in;
    multi_coin  = (nickel_in & dime_in) | (nickel_in & quarter_in) | (dime_in & quarter_in);
    coin_val    = quarter_in ? QUARTER_VAL : dime_in ? DIME_VAL : nickel_in ? NICKEL_VAL : '0;
    sum         = {1'b0, credit} + {1'b0, coin_val};
    accepting   = (state == IDLE) || (state == CREDIT);
    do_select   = accepting && select_in && (credit >= PRICE_V);
    do_cancel   = (state == CREDIT) && cancel_in && !do_select;
    coin_add    = accepting && any_coin && !do_select && !do_cancel && (sum <= MAX_V);
    reject_next = any_coin && (!coin_add || multi_coin);
    active      = (state == CHANGE);
    start       = do_cancel || ((state == VEND) && (cnt == '0) && (credit != '0));
  end

  change_dispenser u_change (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .active     (active),
    .credit     (credit),
    .ret_nickel (ret_nickel),
    .ret_dime   (ret_dime),
    .ret_quarter(ret_quarter),
    .dec        (dec),
    .done       (done)
  );

  always_comb begin
    state_next    = state;
    credit_next   = credit - dec;
    cnt_next      = cnt;
    dispense_next = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if (do_select) begin
          state_next    = VEND;
          credit_next   = credit - PRICE_V;
          cnt_next      = CNT_LAST;
          dispense_next = 1'b1;
        end else if (do_cancel) begin
          state_next = CHANGE;
        end else if (coin_add) begin
          state_next  = CREDIT;
          credit_next = sum[CREDIT_W-1:0];
        end
      end
      VEND: begin
        if (cnt == '0) begin
          state_next = (credit != '0) ? CHANGE : IDLE;
        end else begin
          cnt_next      = cnt - 1'b1;
          dispense_next = 1'b1;
        end
      end
      CHANGE: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      credit      <= '0;
      cnt         <= '0;
      dispense    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      cnt         <= cnt_next;
      dispense    <= dispense_next;
      coin_reject <= reject_next;
      busy        <= (state_next == VEND) || (state_next == CHANGE);
    end
  end

endmodule
